cordic_acc_feeder: RTL
======================

Name: cordic_acc_feeder

Overview:
- Upstream driver for the CORDIC accumulator slave (address 0 = push x, address 1 write = clear accumulator, address 1 read = result, stalls via waitrequest).
- Offloads the Nios II: software programs a memory base address and element count over a CSR slave and starts a run. The block then clears the accumulator, fetches each single-precision float from memory, and pushes it to the accumulator. It finally reads back the sum and latches it for software.

Parameters:
- ADDR_W, 32, memory byte-address width.
- CNT_W, 16, element-count width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- csr_address  in  2  0=BASE, 1=COUNT, 2=CTRL/STATUS, 3=RESULT
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  CSR read data, registered, valid the cycle after csr_read
- mem_read  out  1  memory read request
- mem_address  out  ADDR_W  word-aligned byte address
- mem_readdata  in  32  memory read data
- mem_waitrequest  in  1  memory stall
- acc_write  out  1  accumulator write strobe
- acc_read  out  1  accumulator read strobe
- acc_address  out  1  accumulator register select
- acc_writedata  out  32  accumulator write data
- acc_readdata  in  32  accumulator read data
- acc_waitrequest  in  1  accumulator stall

Behaviour:
- Reset: all strobes 0; mem_address, acc_address, acc_writedata, csr_readdata 0; BASE, COUNT, RESULT, index 0; busy=0, done=0; state IDLE. Reset mid-run aborts immediately: strobes are low the cycle after reset is sampled.
- CSR write decode:
  - BASE: bits [1:0] forced to 0.
  - COUNT: uses low CNT_W bits.
  - CTRL bit0=1: start, honoured only in IDLE. Writes to BASE/COUNT while busy are ignored.
  - CTRL bit1=1: clear done.
- CSR read decode:
  - STATUS: bit0=busy, bit1=done.
  - RESULT: last captured sum.
- Avalon master rule: a strobe, with its address and data, is held stable until the cycle where waitrequest=0. The transfer completes on that edge. Never assert acc_read and acc_write together.
- IDLE: on start, set busy=1, done=0, index=0 -> CLEAR.
- CLEAR: acc_write=1, acc_address=1, acc_writedata=0. On accept -> FETCH if COUNT!=0, else -> RESULT.
- FETCH: mem_read=1, mem_address=BASE+4*index. On accept, capture mem_readdata -> PUSH.
- PUSH: acc_write=1, acc_address=0, acc_writedata=captured word. On accept, index+1. If index+1==COUNT -> RESULT, else -> FETCH.
- RESULT: acc_read=1, acc_address=1. Stays asserted while acc_waitrequest=1, which covers the CORDIC computation latency. On accept, RESULT<=acc_readdata -> DONE.
- DONE: busy=0, done=1 (sticky until cleared or the next start) -> IDLE.
- Minimum cycles per element with zero wait states: 2 (FETCH+PUSH). Zero-wait run total = 1 + 2*COUNT + 1 + 1 cycles from start to done.
- mem_address wraps modulo 2^ADDR_W. COUNT=0 yields the cleared-accumulator value.
- A start written in the same cycle as a done-clear: both are applied, and done ends 0.
- Block performs no float arithmetic; data passes through bit-exact.

Test Plan:
- Reset, then read STATUS and RESULT -> both 0x00000000; all master strobes low.
- BASE=0x1000, COUNT=2, memory[0x1000]=0x437f0000, memory[0x1004]=0x43000000, start, zero wait -> acc sees write addr1 data0, write addr0 0x437f0000, write addr0 0x43000000, then read addr1. Model returns 0x43BF8000 -> RESULT=0x43BF8000, done=1 after 7 cycles.
- Same run with accumulator waitrequest high for 6 cycles on read and memory waitrequest high for 3 cycles per fetch -> strobes and addresses stay stable throughout; final RESULT unchanged.
- COUNT=0, start -> clear write, then result read, no mem_read ever asserted; done=1.
- Start at the 2nd PUSH of COUNT=4, plus a BASE write while busy -> both ignored; the run completes with the original BASE.
- Assert reset during FETCH -> next cycle all strobes 0, busy=0; a subsequent start runs cleanly from index 0.

Source files
------------

// File: rtl/cordic_acc_feeder.sv
// -----------------------------------------------------------------------------
// cordic_acc_feeder
//
// Purpose:
//   Upstream driver for the CORDIC floating-point accumulator slave. Software
//   programs a memory base address and an element count through a small CSR
//   slave, then writes start. The block clears the accumulator, streams every
//   32-bit word from memory into the accumulator push register, reads back
//   the accumulated sum and latches it in RESULT for software. No float
//   arithmetic happens here; data passes through bit-exact.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   csr_*             CSR slave: 0=BASE, 1=COUNT, 2=CTRL/STATUS, 3=RESULT.
//                     csr_readdata is registered, valid the cycle after
//                     csr_read.
//                     CTRL write: bit0=start (IDLE only), bit1=clear done.
//                     STATUS read: bit0=busy, bit1=done.
//   mem_*             Avalon-MM read master towards word memory
//   acc_*             Avalon-MM master towards the accumulator:
//                     address 0 write = push x, address 1 write = clear,
//                     address 1 read = result
//
// Every master strobe, together with its address and data, is a pure decode
// of the FSM state (and of registers that only change when the transfer is
// accepted), so it holds steady while waitrequest is high and drops the cycle
// after reset is sampled.
// -----------------------------------------------------------------------------
module cordic_acc_feeder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    // CSR slave
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    // memory read master
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    // accumulator master
    output logic              acc_write,
    output logic              acc_read,
    output logic              acc_address,
    output logic [31:0]       acc_writedata,
    input  logic [31:0]       acc_readdata,
    input  logic              acc_waitrequest
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_PUSH   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // CSR register map
    localparam logic [1:0] CSR_BASE   = 2'd0;
    localparam logic [1:0] CSR_COUNT  = 2'd1;
    localparam logic [1:0] CSR_CTRL   = 2'd2;
    localparam logic [1:0] CSR_RESULT = 2'd3;

    // Accumulator register selects
    localparam logic ACC_PUSH_SEL = 1'b0;
    localparam logic ACC_CTRL_SEL = 1'b1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]        state_q,        state_d;
    logic [ADDR_W-1:0] base_q,         base_d;
    logic [CNT_W-1:0]  count_q,        count_d;
    logic [CNT_W-1:0]  index_q,        index_d;
    logic [31:0]       word_q,         word_d;
    logic [31:0]       result_q,       result_d;
    logic              busy_q,         busy_d;
    logic              done_q,         done_d;
    logic [31:0]       csr_readdata_q, csr_readdata_d;

    // -------------------------------------------------------------------------
    // CSR write decode
    // -------------------------------------------------------------------------
    logic              wr_base;
    logic              wr_count;
    logic              start_req;
    logic              clr_done_req;
    logic [ADDR_W-1:0] wr_addr_val;

    always_comb begin
        wr_base      = csr_write && (csr_address == CSR_BASE);
        wr_count     = csr_write && (csr_address == CSR_COUNT);
        start_req    = csr_write && (csr_address == CSR_CTRL) && csr_writedata[0];
        clr_done_req = csr_write && (csr_address == CSR_CTRL) && csr_writedata[1];
        wr_addr_val  = ADDR_W'(csr_writedata);
    end

    // -------------------------------------------------------------------------
    // Address generation: BASE + 4*index, wrapping modulo 2^ADDR_W
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] index_ext;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  index_inc;

    always_comb begin
        index_ext  = ADDR_W'(index_q);
        fetch_addr = base_q + (index_ext << 2);
        index_inc  = index_q + CNT_W'(1);
    end

    // -------------------------------------------------------------------------
    // Master outputs, decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        mem_read      = 1'b0;
        mem_address   = '0;
        acc_write     = 1'b0;
        acc_read      = 1'b0;
        acc_address   = 1'b0;
        acc_writedata = 32'd0;
        case (state_q)
            S_CLEAR: begin
                // write 0 to the control register clears the running sum
                acc_write     = 1'b1;
                acc_address   = ACC_CTRL_SEL;
                acc_writedata = 32'd0;
            end
            S_FETCH: begin
                mem_read    = 1'b1;
                mem_address = fetch_addr;
            end
            S_PUSH: begin
                acc_write     = 1'b1;
                acc_address   = ACC_PUSH_SEL;
                acc_writedata = word_q;
            end
            S_RESULT: begin
                // the slave holds waitrequest through the CORDIC latency
                acc_read    = 1'b1;
                acc_address = ACC_CTRL_SEL;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        index_d  = index_q;
        word_d   = word_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    index_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!acc_waitrequest) begin
                    // an empty run goes straight to reading the cleared sum
                    state_d = (count_q != '0) ? S_FETCH : S_RESULT;
                end
            end
            S_FETCH: begin
                if (!mem_waitrequest) begin
                    word_d  = mem_readdata;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (!acc_waitrequest) begin
                    index_d = index_inc;
                    state_d = (index_inc == count_q) ? S_RESULT : S_FETCH;
                end
            end
            S_RESULT: begin
                if (!acc_waitrequest) begin
                    result_d = acc_readdata;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Configuration is frozen for the whole run, including the DONE cycle.
        if (wr_base && !busy_q) begin
            base_d = {wr_addr_val[ADDR_W-1:2], 2'b00};
        end
        if (wr_count && !busy_q) begin
            count_d = CNT_W'(csr_writedata);
        end
        // Clearing done is applied after the FSM so that start+clear in one
        // write, or a clear landing in the DONE cycle, leaves done at 0.
        if (clr_done_req) begin
            done_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // CSR read mux (registered; value held between reads)
    // -------------------------------------------------------------------------
    always_comb begin
        csr_readdata_d = csr_readdata_q;
        if (csr_read) begin
            case (csr_address)
                CSR_BASE:   csr_readdata_d = 32'(base_q);
                CSR_COUNT:  csr_readdata_d = 32'(count_q);
                CSR_CTRL:   csr_readdata_d = {30'd0, done_q, busy_q};
                CSR_RESULT: csr_readdata_d = result_q;
                default:    csr_readdata_d = 32'd0;
            endcase
        end
    end

    assign csr_readdata = csr_readdata_q;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            count_q        <= '0;
            index_q        <= '0;
            word_q         <= 32'd0;
            result_q       <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            csr_readdata_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            count_q        <= count_d;
            index_q        <= index_d;
            word_q         <= word_d;
            result_q       <= result_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            csr_readdata_q <= csr_readdata_d;
        end
    end

endmodule
